assoc_cache: RTL and testbench
==============================

# assoc_cache

Parametrised set-associative, write-back, write-allocate data cache with LRU replacement and explicit invalidate/flush operations. It sits between the core's single-request load/store port (the req_* handshake) and a slow backing-memory port with a req/ack handshake. It generalises the direct-mapped, fixed-geometry data cache in three ways: configurable set count and associativity, dirty tracking with write-back, and a whole-cache flush. Lines are one DATA_W word.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- SETS, 16, number of sets; power of two, ≥2
- WAYS, 2, associativity; power of two, 1..8
- Derived: IDX_W = log2(SETS); TAG_W = ADDR_W−2−IDX_W. Index = req_addr[IDX_W+1:2]; tag = req_addr[ADDR_W−1:IDX_W+2]; req_addr[1:0] ignored.

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_addr  in  ADDR_W  request byte address
- req_data  in  DATA_W  write data
- req_type  in  2  00 read, 01 write, 10 invalidate line, 11 flush all
- req_do  in  1  request strobe, sampled only when busy=0
- O_data  out  DATA_W  read result
- req_done  out  1  one-cycle completion pulse
- busy  out  1  request in progress
- mem_req  out  1  backing-memory request, held until mem_ack
- mem_we  out  1  1 = write-back, 0 = fill read
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0]=0)
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

## Operation
- States: IDLE, LOOKUP, WB, FILL, DONE, FLUSH.
- IDLE: when req_do=1, latch addr/data/type, set busy, and go to LOOKUP. If type=11, go to FLUSH with the entry counter at 0.
- LOOKUP: compare the tag against all valid ways of the set.
  - Read hit: O_data ← way data, update LRU, go to DONE.
  - Write hit: write data, set dirty, O_data ← req_data, update LRU, go to DONE.
  - Miss (read or write): choose the victim. It is the lowest-index invalid way; if none is invalid, the LRU way. If the victim is valid and dirty, go to WB. Otherwise a read goes to FILL and a write installs directly (valid, dirty, tag, data; O_data ← req_data), then goes to DONE.
  - Invalidate: on a hit with dirty set, go to WB and then clear the line. On a hit with dirty clear, clear valid. On a miss, take no action. Then go to DONE.
- WB: mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data. On mem_ack, clear dirty, then continue:
  - Read → FILL.
  - Write → install and go to DONE.
  - Invalidate → clear valid and go to DONE.
- FILL: mem_req=1, mem_we=0, mem_addr=request word address. On mem_ack, install mem_rdata (valid, clean), set O_data ← mem_rdata, update LRU, go to DONE.
- DONE: req_done=1 for exactly one cycle, busy=0, then IDLE.
- FLUSH: visit entry (set, way) once per cycle, index-major. A dirty entry goes through WB and returns to FLUSH. Every visited entry is left invalid. After entry SETS·WAYS−1, go to DONE.
- LRU: each way has a per-set age of log2(WAYS) bits.
  - On access, the accessed way's age becomes 0, and every way younger than it increments.
  - The victim is the way with the maximum age.
  - Reset sets each way's age to its way index.
  - WAYS=1 has no LRU state.
- O_data changes only on read completion and write completion. It holds its value on invalidate and flush.

## Timing
- Reset values: all outputs 0; all valid/dirty bits 0; state IDLE. Data and tag arrays are not reset.
- Hit latency: req_do sampled at edge E0; LOOKUP during the next cycle; req_done high in the cycle after E1, i.e. 2 cycles after the req_do cycle.
- Clean-miss read latency: 2 + memory latency + 1 cycles. A dirty miss adds one full WB transaction.
- req_do while busy=1 is ignored; there is no queueing.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1. mem_req drops in the cycle after mem_ack. mem_ack received while mem_req=0 is ignored.
- Reset asserted mid-operation: the next edge forces IDLE, drops mem_req, clears all valid/dirty bits, and suppresses req_done. Dirty data is lost.

## Test plan
- Memory model: 3-cycle ack; word at address a initialised to a. Geometry: SETS=16, WAYS=2.
- Read 0x3FC cold → one FILL at 0x3FC, O_data=0x0000_03FC, req_done 6 cycles after req_do. Re-read → hit, req_done at +2, no mem_req.
- Write 0x3FC←0xAABB_CCDD (hit) → done at +2, no memory traffic. Read 0x3FC → 0xAABB_CCDD.
- Conflict set 0: read 0x040, then 0x080, write 0x040←0x1234_5678, then read 0x0C0 → victim 0x080 (clean, no WB). Then read 0x100 → WB of 0x040 with 0x1234_5678, then FILL 0x100.
- Invalidate 0x3FC while dirty → WB at 0x3FC with 0xAABB_CCDD. A subsequent read refills 0x3FC with the memory value.
- Flush all with two dirty lines → exactly two writes, req_done after 32 entries plus the WBs. All later reads miss.
- Assert reset during FILL → mem_req=0 next cycle, no req_done, busy=0; a prior hit line now misses.

Source files
------------

// File: rtl/assoc_cache_if.sv
// rtl/assoc_cache_if.sv - core request and backing-memory signals of assoc_cache
interface assoc_cache_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [1:0]        req_type;
   logic              req_do;
   logic [DATA_W-1:0] O_data;
   logic              req_done;
   logic              busy;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output req_addr, req_data, req_type, req_do, mem_rdata, mem_ack,
      input  O_data, req_done, busy, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_addr, req_data, req_type, req_do, mem_rdata, mem_ack,
      output O_data, req_done, busy, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/assoc_cache.sv
// rtl/assoc_cache.sv - set-associative write-back write-allocate data cache with LRU
module assoc_cache #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 16,
   parameter int WAYS   = 2
) (
   input logic          clk,
   input logic          reset,
   assoc_cache_if.slave bus
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - 2 - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);
   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

   localparam logic [1:0] T_READ  = 2'b00;
   localparam logic [1:0] T_WRITE = 2'b01;
   localparam logic [1:0] T_INVAL = 2'b10;
   localparam logic [1:0] T_FLUSH = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB, S_FILL, S_DONE, S_FLUSH
   } state_t;

   state_t state;

   // Line storage; age is the recency rank within a set (0 = most recent).
   logic              valid_q [SETS][WAYS];
   logic              dirty_q [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [DATA_W-1:0] data_q  [SETS][WAYS];
   logic [WAY_W-1:0]  age_q   [SETS][WAYS];

   logic [ADDR_W-1:2] waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        type_q;
   logic [WAY_W-1:0]  vway_q;
   logic [IDX_W-1:0]  fset_q;
   logic [WAY_W-1:0]  fway_q;

   logic [DATA_W-1:0] o_data_q;
   logic              done_q;
   logic              busy_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   assign bus.O_data    = o_data_q;
   assign bus.req_done  = done_q;
   assign bus.busy      = busy_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.req_addr[1:0];

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   assign idx = waddr_q[IDX_W+1:2];
   assign tag = waddr_q[ADDR_W-1:IDX_W+2];

   logic             hit;
   logic             has_inv;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] lru_way;
   logic [WAY_W-1:0] victim;
   logic             victim_dirty;
   logic             hit_dirty;
   logic             flush_dirty;
   logic             flush_last;
   logic [IDX_W-1:0] fset_nx;
   logic [WAY_W-1:0] fway_nx;

   // Tag match, victim choice (first invalid way, else oldest) and flush walk.
   always_comb begin
      hit     = 1'b0;
      has_inv = 1'b0;
      hit_way = '0;
      inv_way = '0;
      lru_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag) && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx][w] && !has_inv) begin
            has_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
         if (age_q[idx][w] == LAST_WAY) begin
            lru_way = WAY_W'(w);
         end
      end
      victim       = has_inv ? inv_way : lru_way;
      victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
      hit_dirty    = dirty_q[idx][hit_way];
      flush_dirty  = valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q];
      flush_last   = (fset_q == LAST_SET) && (fway_q == LAST_WAY);
      fway_nx      = (fway_q == LAST_WAY) ? '0 : fway_q + WAY_W'(1);
      fset_nx      = (fway_q == LAST_WAY) ? fset_q + IDX_W'(1) : fset_q;
   end

   // Age of way w in set s after way acc is touched: acc becomes youngest,
   // ways that were younger than acc each age by one.
   function automatic logic [WAY_W-1:0] new_age(input logic [IDX_W-1:0] s,
                                                input logic [WAY_W-1:0] acc,
                                                input int w);
      logic [WAY_W-1:0] r;
      r = age_q[s][w];
      if (WAY_W'(w) == acc) begin
         r = '0;
      end else if (age_q[s][w] < age_q[s][acc]) begin
         r = age_q[s][w] + WAY_W'(1);
      end
      return r;
   endfunction

   // Controller, line arrays and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         o_data_q    <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         type_q      <= T_READ;
         vway_q      <= '0;
         fset_q      <= '0;
         fway_q      <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               age_q[s][w]   <= WAY_W'(w);
            end
         end
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               if (bus.req_do) begin
                  waddr_q <= bus.req_addr[ADDR_W-1:2];
                  wdata_q <= bus.req_data;
                  type_q  <= bus.req_type;
                  busy_q  <= 1'b1;
                  fset_q  <= '0;
                  fway_q  <= '0;
                  state   <= (bus.req_type == T_FLUSH) ? S_FLUSH : S_LOOKUP;
               end
            end

            S_LOOKUP: begin
               if (type_q == T_INVAL) begin
                  if (hit && hit_dirty) begin
                     vway_q      <= hit_way;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= {tag_q[idx][hit_way], idx, 2'b00};
                     mem_wdata_q <= data_q[idx][hit_way];
                     state       <= S_WB;
                  end else begin
                     if (hit) begin
                        valid_q[idx][hit_way] <= 1'b0;
                     end
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= S_DONE;
                  end
               end else if (hit) begin
                  if (type_q == T_WRITE) begin
                     data_q[idx][hit_way]  <= wdata_q;
                     dirty_q[idx][hit_way] <= 1'b1;
                     o_data_q              <= wdata_q;
                  end else begin
                     o_data_q <= data_q[idx][hit_way];
                  end
                  for (int w = 0; w < WAYS; w++) begin
                     age_q[idx][w] <= new_age(idx, hit_way, w);
                  end
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= S_DONE;
               end else begin
                  vway_q <= victim;
                  if (victim_dirty) begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= {tag_q[idx][victim], idx, 2'b00};
                     mem_wdata_q <= data_q[idx][victim];
                     state       <= S_WB;
                  end else if (type_q == T_READ) begin
                     mem_req_q  <= 1'b1;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= {waddr_q, 2'b00};
                     state      <= S_FILL;
                  end else begin
                     valid_q[idx][victim] <= 1'b1;
                     dirty_q[idx][victim] <= 1'b1;
                     tag_q[idx][victim]   <= tag;
                     data_q[idx][victim]  <= wdata_q;
                     o_data_q             <= wdata_q;
                     for (int w = 0; w < WAYS; w++) begin
                        age_q[idx][w] <= new_age(idx, victim, w);
                     end
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= S_DONE;
                  end
               end
            end

            S_WB: begin
               if (mem_req_q && bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (type_q == T_FLUSH) begin
                     valid_q[fset_q][fway_q] <= 1'b0;
                     dirty_q[fset_q][fway_q] <= 1'b0;
                     if (flush_last) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                     end else begin
                        fset_q <= fset_nx;
                        fway_q <= fway_nx;
                        state  <= S_FLUSH;
                     end
                  end else begin
                     dirty_q[idx][vway_q] <= 1'b0;
                     if (type_q == T_READ) begin
                        state <= S_FILL;
                     end else begin
                        if (type_q == T_WRITE) begin
                           valid_q[idx][vway_q] <= 1'b1;
                           dirty_q[idx][vway_q] <= 1'b1;
                           tag_q[idx][vway_q]   <= tag;
                           data_q[idx][vway_q]  <= wdata_q;
                           o_data_q             <= wdata_q;
                           for (int w = 0; w < WAYS; w++) begin
                              age_q[idx][w] <= new_age(idx, vway_q, w);
                           end
                        end else begin
                           valid_q[idx][vway_q] <= 1'b0;
                        end
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                     end
                  end
               end
            end

            S_FILL: begin
               // After a write-back the request line drops for a cycle first.
               if (!mem_req_q) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= {waddr_q, 2'b00};
               end else if (bus.mem_ack) begin
                  mem_req_q            <= 1'b0;
                  valid_q[idx][vway_q] <= 1'b1;
                  dirty_q[idx][vway_q] <= 1'b0;
                  tag_q[idx][vway_q]   <= tag;
                  data_q[idx][vway_q]  <= bus.mem_rdata;
                  o_data_q             <= bus.mem_rdata;
                  for (int w = 0; w < WAYS; w++) begin
                     age_q[idx][w] <= new_age(idx, vway_q, w);
                  end
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= S_DONE;
               end
            end

            S_FLUSH: begin
               if (flush_dirty) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {tag_q[fset_q][fway_q], fset_q, 2'b00};
                  mem_wdata_q <= data_q[fset_q][fway_q];
                  state       <= S_WB;
               end else begin
                  valid_q[fset_q][fway_q] <= 1'b0;
                  if (flush_last) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= S_DONE;
                  end else begin
                     fset_q <= fset_nx;
                     fway_q <= fway_nx;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_assoc_cache.sv
// tb/tb_assoc_cache.sv - scoreboard bench for assoc_cache with a recency-stamp reference model
`timescale 1ns/1ps
module tb_assoc_cache;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int SETS    = 16;
   localparam int WAYS    = 2;
   localparam int MEM_LAT = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   assoc_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct { logic [31:0] o; int lat; int issue; } exp_t;
   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mop_t;

   exp_t exp_q[$];
   mop_t mop_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   wb_seen = 0;
   int   mcnt = 0;

   logic        m_valid [SETS][WAYS];
   logic        m_dirty [SETS][WAYS];
   logic [31:0] m_line  [SETS][WAYS];
   logic [31:0] m_data  [SETS][WAYS];
   int          m_stamp [SETS][WAYS];
   int          tick;
   logic [31:0] last_o;
   logic [31:0] ref_mem  [logic [31:0]];
   logic [31:0] phys_mem [logic [31:0]];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] phys_rd(input logic [31:0] a);
      return phys_mem.exists(a) ? phys_mem[a] : a;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : a;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_stamp[s][w] = -w;
         end
      tick   = 0;
      last_o = '0;
   endtask

   task automatic model_wb(input int s, input int w);
      mop_t m;
      m.we = 1'b1; m.addr = m_line[s][w]; m.wdata = m_data[s][w];
      mop_q.push_back(m);
      ref_mem[m_line[s][w]] = m_data[s][w];
      m_dirty[s][w] = 1'b0;
   endtask

   task automatic model_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d, input int issue);
      logic [31:0] wa;
      int s, hw, v, nwb;
      exp_t e;
      mop_t m;
      wa = {a[31:2], 2'b00};
      s  = int'(a[5:2]);
      hw = -1;
      v  = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_line[s][w] == wa) hw = w;
      for (int w = WAYS - 1; w >= 0; w--)
         if (!m_valid[s][w]) v = w;
      if (v < 0) begin
         v = 0;
         for (int w = 1; w < WAYS; w++)
            if (m_stamp[s][w] < m_stamp[s][v]) v = w;
      end
      e.o = last_o; e.lat = 2; e.issue = issue;
      case (t)
         2'b00, 2'b01: begin
            if (hw >= 0) begin
               if (t == 2'b01) begin
                  m_data[s][hw] = d;
                  m_dirty[s][hw] = 1'b1;
               end
               e.o = m_data[s][hw];
               m_stamp[s][hw] = ++tick;
            end else begin
               if (m_valid[s][v] && m_dirty[s][v]) begin
                  model_wb(s, v);
                  e.lat = (t == 2'b00) ? 11 : 6;
               end else if (t == 2'b00) begin
                  e.lat = 6;
               end
               m_valid[s][v] = 1'b1;
               m_line[s][v]  = wa;
               if (t == 2'b00) begin
                  m.we = 1'b0; m.addr = wa; m.wdata = '0;
                  mop_q.push_back(m);
                  m_data[s][v]  = ref_rd(wa);
                  m_dirty[s][v] = 1'b0;
               end else begin
                  m_data[s][v]  = d;
                  m_dirty[s][v] = 1'b1;
               end
               e.o = m_data[s][v];
               m_stamp[s][v] = ++tick;
            end
         end
         2'b10: begin
            if (hw >= 0) begin
               if (m_dirty[s][hw]) begin
                  model_wb(s, hw);
                  e.lat = 6;
               end
               m_valid[s][hw] = 1'b0;
            end
         end
         default: begin
            nwb = 0;
            for (int ss = 0; ss < SETS; ss++)
               for (int w = 0; w < WAYS; w++) begin
                  if (m_valid[ss][w] && m_dirty[ss][w]) begin
                     model_wb(ss, w);
                     nwb++;
                  end
                  m_valid[ss][w] = 1'b0;
               end
            e.lat = 33 + 4 * nwb;
         end
      endcase
      last_o = e.o;
      exp_q.push_back(e);
   endtask

   task automatic do_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d, input bit wait_done);
      int k, start;
      @(negedge clk);
      k = 0;
      while (bus.busy && k < 500) begin @(negedge clk); k++; end
      bus.req_type = t;
      bus.req_addr = a;
      bus.req_data = d;
      bus.req_do   = 1'b1;
      start = done_cnt;
      model_req(t, a, d, cyc);
      @(negedge clk);
      bus.req_do = 1'b0;
      if (wait_done) begin
         k = 0;
         while (done_cnt == start && k < 500) begin @(negedge clk); k++; end
         if (done_cnt == start) begin
            n_cmp++; n_bad++;
            $display("FAIL req_timeout: no req_done for type %0d addr 0x%08h after %0d cycles", t, a, k);
         end
      end
   endtask

   // Backing memory: acks MEM_LAT cycles after it first sees mem_req.
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            mcnt = 0;
         end else if (bus.mem_req) begin
            mcnt++;
            if (mcnt == MEM_LAT + 1) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_we) phys_mem[bus.mem_addr] = bus.mem_wdata;
               else            bus.mem_rdata = phys_rd(bus.mem_addr);
            end
         end else begin
            mcnt = 0;
         end
      end
   end

   // Response and memory-traffic monitor.
   always @(negedge clk) begin
      exp_t e;
      mop_t m;
      if (!reset && bus.req_done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got req_done, expected none (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("o_data", bus.O_data, e.o);
            chk("latency", 32'(cyc - e.issue), 32'(e.lat));
         end
      end
      if (!reset && bus.mem_req && bus.mem_ack) begin
         if (bus.mem_we) wb_seen++;
         if (mop_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_mem: got we=%0d addr 0x%08h, expected no memory access", bus.mem_we, bus.mem_addr);
         end else begin
            m = mop_q.pop_front();
            chk("mem_we", 32'(bus.mem_we), 32'(m.we));
            chk("mem_addr", bus.mem_addr, m.addr);
            if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int k, start, wb0, r;
      logic [1:0]  t;
      logic [31:0] a;
      bus.req_do = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_type = '0;
      reset = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_busy",      32'(bus.busy), 0);
      chk("rst_req_done",  32'(bus.req_done), 0);
      chk("rst_o_data",    bus.O_data, 0);
      chk("rst_mem_req",   32'(bus.mem_req), 0);
      chk("rst_mem_we",    32'(bus.mem_we), 0);
      chk("rst_mem_addr",  bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      reset = 1'b0;

      do_req(2'b00, 32'h3FC, 0, 1);
      do_req(2'b00, 32'h3FC, 0, 1);
      do_req(2'b01, 32'h3FC, 32'hAABB_CCDD, 1);
      do_req(2'b00, 32'h3FC, 0, 1);
      do_req(2'b00, 32'h040, 0, 1);
      do_req(2'b00, 32'h080, 0, 1);
      do_req(2'b01, 32'h040, 32'h1234_5678, 1);
      do_req(2'b00, 32'h0C0, 0, 1);
      do_req(2'b00, 32'h100, 0, 1);
      do_req(2'b10, 32'h3FC, 0, 1);
      do_req(2'b00, 32'h3FC, 0, 1);
      do_req(2'b01, 32'h104, 32'h0BAD_F00D, 1);
      do_req(2'b01, 32'h208, 32'hCAFE_0001, 1);
      wb0 = wb_seen;
      do_req(2'b11, 32'h0, 0, 1);
      chk("flush_wb_count", 32'(wb_seen - wb0), 2);
      do_req(2'b00, 32'h104, 0, 1);
      do_req(2'b00, 32'h3FC, 0, 1);

      // Reset in the middle of a fill after establishing a hit line.
      do_req(2'b00, 32'h200, 0, 1);
      do_req(2'b00, 32'h200, 0, 1);
      do_req(2'b00, 32'h7C4, 0, 0);
      k = 0;
      while (!bus.mem_req && k < 50) begin @(negedge clk); k++; end
      chk("fill_started", 32'(bus.mem_req), 1);
      reset = 1'b1;
      start = done_cnt;
      @(negedge clk);
      chk("rst_mid_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mid_busy",    32'(bus.busy), 0);
      chk("rst_mid_done",    32'(bus.req_done), 0);
      chk("rst_mid_o_data",  bus.O_data, 0);
      reset = 1'b0;
      exp_q.delete();
      mop_q.delete();
      model_reset();
      repeat (10) @(negedge clk);
      chk("rst_mid_no_done", 32'(done_cnt - start), 0);
      do_req(2'b00, 32'h200, 0, 1);

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         t = (r < 45) ? 2'b00 : (r < 85) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
         a = 32'($urandom_range(0, 5)) << 6 | 32'($urandom_range(0, 3)) << 2 | 32'($urandom_range(0, 3));
         do_req(t, a, $urandom, 1);
      end

      repeat (10) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 0);
      chk("mop_q_drained", 32'(mop_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
